ip_tx_arbiter_64: RTL and testbench

//  Shares the single IP TX input of the IPv4 block (s_ip_* header + 64-bit payload) among S_COUNT requesters, e.g. RoCE TX and UDP TX.

---
 rtl/ip_tx_arbiter_64.sv | 161 ++++++++++++++++
 tb/tb_ip_tx_arbiter_64.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_tx_arbiter_64.sv
// Per-packet arbiter that shares one IP TX header+payload channel among S_COUNT requesters.
// A grant is held from header acceptance through the tlast beat, then re-arbitrated after one idle cycle.
module ip_tx_arbiter_64 #(
   parameter int S_COUNT     = 2,
   parameter int DATA_WIDTH  = 64,
   parameter int KEEP_WIDTH  = 8,
   parameter int ROUND_ROBIN = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [S_COUNT-1:0]            s_ip_hdr_valid,
   output logic [S_COUNT-1:0]            s_ip_hdr_ready,
   input  logic [S_COUNT*6-1:0]          s_ip_dscp,
   input  logic [S_COUNT*2-1:0]          s_ip_ecn,
   input  logic [S_COUNT*16-1:0]         s_ip_length,
   input  logic [S_COUNT*8-1:0]          s_ip_ttl,
   input  logic [S_COUNT*8-1:0]          s_ip_protocol,
   input  logic [S_COUNT*32-1:0]         s_ip_source_ip,
   input  logic [S_COUNT*32-1:0]         s_ip_dest_ip,
   input  logic [S_COUNT-1:0]            s_is_roce_packet,
   input  logic [S_COUNT*DATA_WIDTH-1:0] s_ip_payload_axis_tdata,
   input  logic [S_COUNT*KEEP_WIDTH-1:0] s_ip_payload_axis_tkeep,
   input  logic [S_COUNT-1:0]            s_ip_payload_axis_tvalid,
   output logic [S_COUNT-1:0]            s_ip_payload_axis_tready,
   input  logic [S_COUNT-1:0]            s_ip_payload_axis_tlast,
   input  logic [S_COUNT-1:0]            s_ip_payload_axis_tuser,
   output logic                          m_ip_hdr_valid,
   input  logic                          m_ip_hdr_ready,
   output logic [5:0]                    m_ip_dscp,
   output logic [1:0]                    m_ip_ecn,
   output logic [15:0]                   m_ip_length,
   output logic [7:0]                    m_ip_ttl,
   output logic [7:0]                    m_ip_protocol,
   output logic [31:0]                   m_ip_source_ip,
   output logic [31:0]                   m_ip_dest_ip,
   output logic                          m_is_roce_packet,
   output logic [DATA_WIDTH-1:0]         m_ip_payload_axis_tdata,
   output logic [KEEP_WIDTH-1:0]         m_ip_payload_axis_tkeep,
   output logic                          m_ip_payload_axis_tvalid,
   input  logic                          m_ip_payload_axis_tready,
   output logic                          m_ip_payload_axis_tlast,
   output logic                          m_ip_payload_axis_tuser,
   output logic [2:0]                    grant_index,
   output logic                          busy
);

   localparam int IDX_W = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAYLOAD} state_t;

   state_t             state_reg, state_next;
   logic [IDX_W-1:0]   grant_reg, grant_next;
   logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [IDX_W-1:0]   scan_idx;
   logic [IDX_W-1:0]   winner;
   logic               winner_found;

   logic [5:0]            dscp_arr  [S_COUNT];
   logic [1:0]            ecn_arr   [S_COUNT];
   logic [15:0]           length_arr[S_COUNT];
   logic [7:0]            ttl_arr   [S_COUNT];
   logic [7:0]            proto_arr [S_COUNT];
   logic [31:0]           src_arr   [S_COUNT];
   logic [31:0]           dst_arr   [S_COUNT];
   logic [DATA_WIDTH-1:0] data_arr  [S_COUNT];
   logic [KEEP_WIDTH-1:0] keep_arr  [S_COUNT];

   // Unpack the flat per-requester buses so the output mux is a plain array index.
   for (genvar gi = 0; gi < S_COUNT; gi++) begin : g_unpack
      assign dscp_arr[gi]   = s_ip_dscp[gi*6 +: 6];
      assign ecn_arr[gi]    = s_ip_ecn[gi*2 +: 2];
      assign length_arr[gi] = s_ip_length[gi*16 +: 16];
      assign ttl_arr[gi]    = s_ip_ttl[gi*8 +: 8];
      assign proto_arr[gi]  = s_ip_protocol[gi*8 +: 8];
      assign src_arr[gi]    = s_ip_source_ip[gi*32 +: 32];
      assign dst_arr[gi]    = s_ip_dest_ip[gi*32 +: 32];
      assign data_arr[gi]   = s_ip_payload_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
      assign keep_arr[gi]   = s_ip_payload_axis_tkeep[gi*KEEP_WIDTH +: KEEP_WIDTH];
   end

   // Round-robin scans from the pointer and wraps to 0; fixed priority scans from 0.
   always_comb begin
      winner       = '0;
      winner_found = 1'b0;
      scan_idx     = '0;
      for (int i = 0; i < S_COUNT; i++) begin
         if (ROUND_ROBIN != 0) begin
            scan_idx = IDX_W'((int'(rr_ptr_reg) + i) % S_COUNT);
         end else begin
            scan_idx = IDX_W'(i);
         end
         if (!winner_found && s_ip_hdr_valid[scan_idx]) begin
            winner_found = 1'b1;
            winner       = scan_idx;
         end
      end
   end

   always_comb begin
      state_next               = state_reg;
      grant_next               = grant_reg;
      rr_ptr_next              = rr_ptr_reg;
      s_ip_hdr_ready           = '0;
      s_ip_payload_axis_tready = '0;
      m_ip_hdr_valid           = 1'b0;
      m_ip_payload_axis_tvalid = 1'b0;
      unique case (state_reg)
         S_IDLE: begin
            if (winner_found) begin
               grant_next = winner;
               state_next = S_HDR;
            end
         end
         S_HDR: begin
            m_ip_hdr_valid            = s_ip_hdr_valid[grant_reg];
            s_ip_hdr_ready[grant_reg] = m_ip_hdr_ready;
            if (s_ip_hdr_valid[grant_reg] && m_ip_hdr_ready) begin
               state_next = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            m_ip_payload_axis_tvalid            = s_ip_payload_axis_tvalid[grant_reg];
            s_ip_payload_axis_tready[grant_reg] = m_ip_payload_axis_tready;
            if (s_ip_payload_axis_tvalid[grant_reg] && m_ip_payload_axis_tready &&
                s_ip_payload_axis_tlast[grant_reg]) begin
               state_next  = S_IDLE;
               rr_ptr_next = (int'(grant_reg) == S_COUNT - 1) ? '0 : grant_reg + 1'b1;
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         grant_reg  <= '0;
         rr_ptr_reg <= '0;
      end else begin
         state_reg  <= state_next;
         grant_reg  <= grant_next;
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   assign m_ip_dscp               = dscp_arr[grant_reg];
   assign m_ip_ecn                = ecn_arr[grant_reg];
   assign m_ip_length             = length_arr[grant_reg];
   assign m_ip_ttl                = ttl_arr[grant_reg];
   assign m_ip_protocol           = proto_arr[grant_reg];
   assign m_ip_source_ip          = src_arr[grant_reg];
   assign m_ip_dest_ip            = dst_arr[grant_reg];
   assign m_is_roce_packet        = s_is_roce_packet[grant_reg];
   assign m_ip_payload_axis_tdata = data_arr[grant_reg];
   assign m_ip_payload_axis_tkeep = keep_arr[grant_reg];
   assign m_ip_payload_axis_tlast = s_ip_payload_axis_tlast[grant_reg];
   assign m_ip_payload_axis_tuser = s_ip_payload_axis_tuser[grant_reg];
   assign grant_index             = 3'(grant_reg);
   assign busy                    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_ip_tx_arbiter_64.sv
// Scoreboard bench for ip_tx_arbiter_64: behavioural requesters feed a round-robin instance,
// a second fixed-priority instance checks lowest-index-wins.
module tb_ip_tx_arbiter_64;
   localparam int S  = 2;
   localparam int DW = 64;
   localparam int KW = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [S-1:0]    s_ip_hdr_valid, s_ip_hdr_ready;
   logic [S*6-1:0]  s_ip_dscp;
   logic [S*2-1:0]  s_ip_ecn;
   logic [S*16-1:0] s_ip_length;
   logic [S*8-1:0]  s_ip_ttl, s_ip_protocol;
   logic [S*32-1:0] s_ip_source_ip, s_ip_dest_ip;
   logic [S-1:0]    s_is_roce_packet;
   logic [S*DW-1:0] s_tdata;
   logic [S*KW-1:0] s_tkeep;
   logic [S-1:0]    s_tvalid, s_tready, s_tlast, s_tuser;
   logic            m_ip_hdr_valid, m_ip_hdr_ready;
   logic [5:0]      m_ip_dscp;
   logic [1:0]      m_ip_ecn;
   logic [15:0]     m_ip_length;
   logic [7:0]      m_ip_ttl, m_ip_protocol;
   logic [31:0]     m_ip_source_ip, m_ip_dest_ip;
   logic            m_is_roce_packet;
   logic [DW-1:0]   m_tdata;
   logic [KW-1:0]   m_tkeep;
   logic            m_tvalid, m_tready, m_tlast, m_tuser;
   logic [2:0]      grant_index;
   logic            busy;

   // fixed-priority instance: own handshakes, shares the data/header buses
   logic [S-1:0]    fp_hdr_valid, fp_hdr_ready, fp_tvalid, fp_tready, fp_tlast;
   logic            fp_m_hdr_valid, fp_m_hdr_ready, fp_m_is_roce;
   logic [5:0]      fp_m_dscp;
   logic [1:0]      fp_m_ecn;
   logic [15:0]     fp_m_length;
   logic [7:0]      fp_m_ttl, fp_m_protocol;
   logic [31:0]     fp_m_src, fp_m_dst;
   logic [DW-1:0]   fp_m_tdata;
   logic [KW-1:0]   fp_m_tkeep;
   logic            fp_m_tvalid, fp_m_tready, fp_m_tlast, fp_m_tuser;
   logic [2:0]      fp_grant_index;
   logic            fp_busy;

   ip_tx_arbiter_64 #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ROUND_ROBIN(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_ip_hdr_valid(s_ip_hdr_valid), .s_ip_hdr_ready(s_ip_hdr_ready),
      .s_ip_dscp(s_ip_dscp), .s_ip_ecn(s_ip_ecn), .s_ip_length(s_ip_length),
      .s_ip_ttl(s_ip_ttl), .s_ip_protocol(s_ip_protocol),
      .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
      .s_is_roce_packet(s_is_roce_packet),
      .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tkeep(s_tkeep),
      .s_ip_payload_axis_tvalid(s_tvalid), .s_ip_payload_axis_tready(s_tready),
      .s_ip_payload_axis_tlast(s_tlast), .s_ip_payload_axis_tuser(s_tuser),
      .m_ip_hdr_valid(m_ip_hdr_valid), .m_ip_hdr_ready(m_ip_hdr_ready),
      .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn), .m_ip_length(m_ip_length),
      .m_ip_ttl(m_ip_ttl), .m_ip_protocol(m_ip_protocol),
      .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
      .m_is_roce_packet(m_is_roce_packet),
      .m_ip_payload_axis_tdata(m_tdata), .m_ip_payload_axis_tkeep(m_tkeep),
      .m_ip_payload_axis_tvalid(m_tvalid), .m_ip_payload_axis_tready(m_tready),
      .m_ip_payload_axis_tlast(m_tlast), .m_ip_payload_axis_tuser(m_tuser),
      .grant_index(grant_index), .busy(busy)
   );

   ip_tx_arbiter_64 #(.S_COUNT(S), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ROUND_ROBIN(0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .s_ip_hdr_valid(fp_hdr_valid), .s_ip_hdr_ready(fp_hdr_ready),
      .s_ip_dscp(s_ip_dscp), .s_ip_ecn(s_ip_ecn), .s_ip_length(s_ip_length),
      .s_ip_ttl(s_ip_ttl), .s_ip_protocol(s_ip_protocol),
      .s_ip_source_ip(s_ip_source_ip), .s_ip_dest_ip(s_ip_dest_ip),
      .s_is_roce_packet(s_is_roce_packet),
      .s_ip_payload_axis_tdata(s_tdata), .s_ip_payload_axis_tkeep(s_tkeep),
      .s_ip_payload_axis_tvalid(fp_tvalid), .s_ip_payload_axis_tready(fp_tready),
      .s_ip_payload_axis_tlast(fp_tlast), .s_ip_payload_axis_tuser(s_tuser),
      .m_ip_hdr_valid(fp_m_hdr_valid), .m_ip_hdr_ready(fp_m_hdr_ready),
      .m_ip_dscp(fp_m_dscp), .m_ip_ecn(fp_m_ecn), .m_ip_length(fp_m_length),
      .m_ip_ttl(fp_m_ttl), .m_ip_protocol(fp_m_protocol),
      .m_ip_source_ip(fp_m_src), .m_ip_dest_ip(fp_m_dst),
      .m_is_roce_packet(fp_m_is_roce),
      .m_ip_payload_axis_tdata(fp_m_tdata), .m_ip_payload_axis_tkeep(fp_m_tkeep),
      .m_ip_payload_axis_tvalid(fp_m_tvalid), .m_ip_payload_axis_tready(fp_m_tready),
      .m_ip_payload_axis_tlast(fp_m_tlast), .m_ip_payload_axis_tuser(fp_m_tuser),
      .grant_index(fp_grant_index), .busy(fp_busy)
   );

   typedef struct {
      logic [15:0] len;
      logic [31:0] dst;
      int          nb;
      logic [63:0] base;
      logic [7:0]  lk;
   } pkt_t;

   typedef struct {
      int           r;
      logic [127:0] w;
   } hexp_t;

   hexp_t        exp_hdr[$];
   logic [127:0] exp_beat[$];
   pkt_t         rq0[$], rq1[$];
   pkt_t         cur[S];
   bit           act[S], hs[S];
   int           beat[S];

   int           n_vec = 0, n_err = 0, cyc = 0;
   logic         m_hdr_rdy = 1'b1;
   bit           trdy_mode = 1'b0;
   logic [3:0]   pat = 4'b1001;
   logic         obs_mhv;
   logic [127:0] obs_hdr, hold_word;
   bit           tl1, tl2, req_bub;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   function automatic logic [127:0] hdr_word(int r, logic [15:0] len, logic [31:0] dst);
      return {23'd0, 6'(r + 5), 2'(r + 1), len, 8'(64 + r), (r == 0) ? 8'hFE : 8'd17,
              32'hC0A8_0000 + 32'(r), dst, (r == 0)};
   endfunction

   function automatic logic [127:0] beat_word(logic [63:0] d, logic [7:0] k, logic l, logic u);
      return {54'd0, d, k, l, u};
   endfunction

   // expected order of enq calls is the expected grant order
   task automatic enq(int r, logic [15:0] len, logic [31:0] dst, int nb, logic [63:0] base, logic [7:0] lk);
      pkt_t  p;
      hexp_t h;
      p.len = len; p.dst = dst; p.nb = nb; p.base = base; p.lk = lk;
      if (r == 0) rq0.push_back(p); else rq1.push_back(p);
      h.r = r; h.w = hdr_word(r, len, dst);
      exp_hdr.push_back(h);
      for (int b = 0; b < nb; b++)
         exp_beat.push_back(beat_word(base + 64'(b), (b == nb - 1) ? lk : 8'hFF,
                                      (b == nb - 1), 1'(b)));
   endtask

   task automatic drive_inputs();
      for (int r = 0; r < S; r++) begin
         if (rst_n && !act[r]) begin
            if (r == 0 && rq0.size() > 0) begin cur[0] = rq0.pop_front(); act[0] = 1; hs[0] = 0; beat[0] = 0; end
            if (r == 1 && rq1.size() > 0) begin cur[1] = rq1.pop_front(); act[1] = 1; hs[1] = 0; beat[1] = 0; end
         end
         s_ip_hdr_valid[r]        = act[r] && !hs[r];
         s_ip_dscp[r*6 +: 6]      = 6'(r + 5);
         s_ip_ecn[r*2 +: 2]       = 2'(r + 1);
         s_ip_length[r*16 +: 16]  = cur[r].len;
         s_ip_ttl[r*8 +: 8]       = 8'(64 + r);
         s_ip_protocol[r*8 +: 8]  = (r == 0) ? 8'hFE : 8'd17;
         s_ip_source_ip[r*32 +: 32] = 32'hC0A8_0000 + 32'(r);
         s_ip_dest_ip[r*32 +: 32] = cur[r].dst;
         s_is_roce_packet[r]      = (r == 0);
         s_tvalid[r]              = act[r];
         s_tlast[r]               = (beat[r] == cur[r].nb - 1);
         s_tdata[r*DW +: DW]      = cur[r].base + 64'(beat[r]);
         s_tkeep[r*KW +: KW]      = s_tlast[r] ? cur[r].lk : 8'hFF;
         s_tuser[r]               = 1'(beat[r]);
      end
      m_ip_hdr_ready = m_hdr_rdy;
      m_tready       = trdy_mode ? pat[cyc % 4] : 1'b1;
   endtask

   task automatic monitor();
      logic [S-1:0] gmask;
      bit           tl_now;
      hexp_t        h;
      logic [127:0] b;
      gmask   = 2'b01 << grant_index;
      obs_mhv = m_ip_hdr_valid;
      obs_hdr = {23'd0, m_ip_dscp, m_ip_ecn, m_ip_length, m_ip_ttl, m_ip_protocol,
                 m_ip_source_ip, m_ip_dest_ip, m_is_roce_packet};
      check("ngr_hdr_rdy", s_ip_hdr_ready & ~gmask, 0);
      check("ngr_tready", s_tready & ~gmask, 0);
      if (m_ip_hdr_valid) check("pl_blocked", m_tvalid, 0);
      if (tl1) check("bubble_busy", busy, 0);
      if (tl2 && req_bub) check("rearb_hdr_valid", m_ip_hdr_valid, 1);
      if (m_ip_hdr_valid && m_ip_hdr_ready) begin
         if (exp_hdr.size() == 0) check("hdr_extra", 1, exp_hdr.size());
         else begin
            h = exp_hdr.pop_front();
            check("hdr", obs_hdr, h.w);
            check("gnt", grant_index, h.r);
         end
      end
      tl_now = m_tvalid && m_tready && m_tlast;
      if (m_tvalid && m_tready) begin
         if (exp_beat.size() == 0) check("beat_extra", 1, exp_beat.size());
         else begin
            b = exp_beat.pop_front();
            check("beat", beat_word(m_tdata, m_tkeep, m_tlast, m_tuser), b);
         end
      end
      req_bub = tl1 && (|s_ip_hdr_valid);
      tl2 = tl1;
      tl1 = tl_now;
      for (int r = 0; r < S; r++) begin
         if (s_ip_hdr_valid[r] && s_ip_hdr_ready[r]) hs[r] = 1;
         if (s_tvalid[r] && s_tready[r]) begin
            if (s_tlast[r]) act[r] = 0;
            beat[r]++;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      drive_inputs();
      #1;
      monitor();
      cyc++;
      @(posedge clk);
   endtask

   function automatic bit pending();
      return act[0] || act[1] || rq0.size() > 0 || rq1.size() > 0 ||
             exp_hdr.size() > 0 || exp_beat.size() > 0;
   endfunction

   task automatic run(int budget);
      int n = 0;
      while (pending() && n < budget) begin cycle(); n++; end
      cycle();
      cycle();
      check("drain_hdr", exp_hdr.size(), 0);
      check("drain_beat", exp_beat.size(), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      s_ip_hdr_valid = '1; s_tvalid = '1; s_tlast = '0; s_tuser = '0;
      s_ip_dscp = '0; s_ip_ecn = '0; s_ip_length = '0; s_ip_ttl = '0; s_ip_protocol = '0;
      s_ip_source_ip = '0; s_ip_dest_ip = '0; s_is_roce_packet = '0; s_tdata = '0; s_tkeep = '0;
      m_ip_hdr_ready = 1'b1; m_tready = 1'b1;
      fp_hdr_valid = '0; fp_tvalid = '0; fp_tlast = '1; fp_m_hdr_ready = 1'b0; fp_m_tready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {busy, grant_index, m_ip_hdr_valid, m_tvalid, s_ip_hdr_ready, s_tready}, 0);
      @(negedge clk);
      s_ip_hdr_valid = '0; s_tvalid = '0;
      rst_n = 1'b1;

      // simultaneous requests, round robin: 0,1,0,1
      enq(0, 16'h0010, 32'h0A00_0010, 2, 64'h1000, 8'hFF);
      enq(1, 16'h0011, 32'h0A00_0011, 3, 64'h2000, 8'h7F);
      enq(0, 16'h0012, 32'h0A00_0012, 1, 64'h3000, 8'h01);
      enq(1, 16'h0013, 32'h0A00_0013, 2, 64'h4000, 8'hFF);
      run(200);

      // req0 alone, 8 beats, 1-cycle header latency
      enq(0, 16'h0040, 32'h0A00_0002, 8, 64'hA000, 8'hFF);
      cycle();
      check("hdr_lat_c0", obs_mhv, 0);
      cycle();
      check("hdr_lat_c1", obs_mhv, 1);
      run(200);

      // m tready 1,0,0,1 with both requesters active (pointer now at 1)
      trdy_mode = 1'b1;
      enq(1, 16'h0050, 32'h0A00_0050, 5, 64'hB000, 8'h3F);
      enq(0, 16'h0051, 32'h0A00_0051, 6, 64'hC000, 8'hFF);
      run(300);
      trdy_mode = 1'b0;

      // single-beat packet from req1, then req0
      enq(1, 16'h0008, 32'h0A00_0008, 1, 64'hD000, 8'h0F);
      cycle();
      cycle();
      enq(0, 16'h0009, 32'h0A00_0009, 2, 64'hE000, 8'h3F);
      run(200);

      // header backpressure for 5 cycles
      m_hdr_rdy = 1'b0;
      enq(0, 16'h0060, 32'h0A00_0060, 2, 64'hF000, 8'hFF);
      cycle();
      hold_word = '0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         check("hdr_hold_valid", obs_mhv, 1);
         if (i == 0) hold_word = obs_hdr;
         else check("hdr_hold_fields", obs_hdr, hold_word);
      end
      m_hdr_rdy = 1'b1;
      run(200);

      // reset during beat 3 of 6
      enq(0, 16'h0070, 32'h0A00_0070, 6, 64'h5000, 8'hFF);
      for (int i = 0; i < 100 && beat[0] < 2; i++) cycle();
      @(negedge clk);
      drive_inputs();
      rst_n = 1'b0;
      #1;
      check("rst_abort", {busy, grant_index, m_ip_hdr_valid, m_tvalid, s_ip_hdr_ready, s_tready}, 0);
      act[0] = 0; act[1] = 0; rq0.delete(); rq1.delete();
      exp_hdr.delete(); exp_beat.delete();
      tl1 = 0; tl2 = 0; req_bub = 0;
      drive_inputs();
      @(posedge clk);
      #1;
      check("rst_edge", {busy, m_ip_hdr_valid, m_tvalid, m_tlast && m_tvalid, s_ip_hdr_ready, s_tready}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      enq(0, 16'h0080, 32'h0A00_0080, 3, 64'h6000, 8'h07);
      run(200);

      // fixed priority: both always requesting single-beat packets, 0 must always win
      @(negedge clk);
      fp_hdr_valid = 2'b11; fp_tvalid = 2'b11; fp_m_hdr_ready = 1'b1; fp_m_tready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #1;
         if (fp_busy) check("fp_gnt", fp_grant_index, 0);
         if (fp_m_hdr_valid) check("fp_hdr_ready1", fp_hdr_ready[1], 0);
      end
      fp_hdr_valid = '0; fp_tvalid = '0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
